// File: rtl/lot_sensor_pkg.sv
// Shared definitions for the two-sensor parking-lot stimulus driver.
//   state_t       : FSM encoding (IDLE, PH1, PH2, PH3, GAP)
//   DIR_*         : command direction encoding on cmd_dir
//   AB_*          : sensor patterns, packed as {a, b} (1 = blocked)
//   first_pattern : {a,b} for PH1 of a command
//   third_pattern : {a,b} for PH3 of a command (balk returns to the PH1 pattern)
package lot_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam logic [1:0] AB_CLEAR  = 2'b00;
  localparam logic [1:0] AB_A_ONLY = 2'b10;
  localparam logic [1:0] AB_B_ONLY = 2'b01;
  localparam logic [1:0] AB_BOTH   = 2'b11;

  // The sensor nearest the car's origin is blocked first.
  function automatic logic [1:0] first_pattern(input logic dir);
    if (dir == DIR_EXIT) begin
      return AB_B_ONLY;
    end else begin
      return AB_A_ONLY;
    end
  endfunction

  // A completed pass leaves via the far sensor; a balk backs out over the near one.
  function automatic logic [1:0] third_pattern(input logic dir, input logic balk);
    if (dir == DIR_EXIT) begin
      return balk ? AB_B_ONLY : AB_A_ONLY;
    end else begin
      return balk ? AB_A_ONLY : AB_B_ONLY;
    end
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase dwell timer: a loadable down-counter that stops at zero.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_val on the next edge (has priority over dec)
//   load_val   : value to load (phase length minus one)
//   dec        : decrement by one when non-zero
//   count      : current counter value
//   zero       : count == 0, i.e. this is the last cycle of the phase
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Down-counter with load priority; saturates at zero so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/lot_sensor_driver.sv
// Transmitter for the two photo-sensor parking-lot interface. Each accepted
// command plays PH1, PH2, PH3 and GAP, each lasting D = max(dwell,1) cycles.
//   clk, reset : clock and synchronous active-high reset
//   cmd_valid  : command request, accepted when cmd_ready is high
//   cmd_ready  : idle and able to accept a command
//   cmd_dir    : 0 = enter (a first), 1 = exit (b first)
//   cmd_balk   : car backs out after both sensors are blocked
//   dwell      : cycles per phase, latched on accept (0 behaves as 1)
//   a, b       : outer / inner sensor, 1 = blocked, registered
//   busy       : sequence in progress (inverse of cmd_ready)
//   done_tick  : one-cycle pulse in the final cycle of each sequence
module lot_sensor_driver
  import lot_sensor_pkg::*;
#(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic               cmd_balk,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done_tick
);

  localparam logic [DWELL_W-1:0] ZERO_W = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] ONE_W  = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic               dir_r;
  logic               balk_r;
  logic [DWELL_W-1:0] dm1_r;      // latched phase length minus one
  logic [1:0]         ab_r;
  logic               done_r;

  logic [DWELL_W-1:0] dwell_m1_s;
  logic               load_s;
  logic [DWELL_W-1:0] load_val_s;
  logic               dec_s;
  logic [DWELL_W-1:0] count_s;
  logic               zero_s;

  // D-1 with dwell = 0 folded onto dwell = 1; all-ones stays 2^W-2, no wrap.
  always_comb begin
    if (dwell == ZERO_W) begin
      dwell_m1_s = ZERO_W;
    end else begin
      dwell_m1_s = dwell - ONE_W;
    end
  end

  // Timer reload: on accept from the live input, on later phase boundaries from the latch.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = dm1_r;
    if (state_r == ST_IDLE) begin
      load_s     = cmd_valid;
      load_val_s = dwell_m1_s;
    end else if (zero_s && (state_r != ST_GAP)) begin
      load_s     = 1'b1;
      load_val_s = dm1_r;
    end else begin
      load_s     = 1'b0;
      load_val_s = dm1_r;
    end
  end

  assign dec_s = (state_r != ST_IDLE);

  phase_timer #(
    .W(DWELL_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .dec      (dec_s),
    .count    (count_s),
    .zero     (zero_s)
  );

  // Sequencer FSM with command latch; a/b and done_tick are registered on the
  // same edge as the state change so they line up with the phase boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      dir_r   <= 1'b0;
      balk_r  <= 1'b0;
      dm1_r   <= ZERO_W;
      ab_r    <= AB_CLEAR;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (cmd_valid) begin
            state_r <= ST_PH1;
            dir_r   <= cmd_dir;
            balk_r  <= cmd_balk;
            dm1_r   <= dwell_m1_s;
            ab_r    <= first_pattern(cmd_dir);
          end else begin
            ab_r <= AB_CLEAR;
          end
        end
        ST_PH1: begin
          done_r <= 1'b0;
          if (zero_s) begin
            state_r <= ST_PH2;
            ab_r    <= AB_BOTH;
          end
        end
        ST_PH2: begin
          done_r <= 1'b0;
          if (zero_s) begin
            state_r <= ST_PH3;
            ab_r    <= third_pattern(dir_r, balk_r);
          end
        end
        ST_PH3: begin
          if (zero_s) begin
            state_r <= ST_GAP;
            ab_r    <= AB_CLEAR;
            // With a one-cycle GAP its first cycle is also the last.
            done_r  <= (dm1_r == ZERO_W);
          end else begin
            done_r <= 1'b0;
          end
        end
        ST_GAP: begin
          // Count of one now means the next cycle is the final one.
          done_r <= (count_s == ONE_W);
          if (zero_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ab_r    <= AB_CLEAR;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign a         = ab_r[1];
  assign b         = ab_r[0];
  assign done_tick = done_r;
  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = ~cmd_ready;

endmodule

// File: tb/tb_lot_sensor_driver.sv
// Scoreboard bench for lot_sensor_driver. The driver models acceptance at the
// command level and queues each accepted command; a monitor on the falling
// edge derives the expected a/b/ready/busy/done from the queue head using
// plain phase arithmetic and pops the command in its final cycle.
module tb_lot_sensor_driver;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic          cmd_balk = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic          a, b, busy, done_tick;

  typedef struct {
    int   k;      // accept edge
    logic dir;
    logic balk;
    int   d;      // cycles per phase
  } cmd_t;

  cmd_t exp_q[$];
  int   acc_q[$];
  int   edge_cnt = 0;
  int   busy_until = 0;
  int   last_k = 0;
  bit   mon_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  lot_sensor_driver #(.DWELL_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_balk  (cmd_balk),
    .dwell     (dwell),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done_tick (done_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(string nm, int act, int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, edge_cnt + 1, act, req);
    end
  endtask

  // Sensor sequence as a car would produce it: near sensor, both, far sensor
  // (or near again when backing out), then clear.
  function automatic logic [1:0] exp_ab(logic dir, logic balk, int ph);
    logic [1:0] first;
    first = dir ? 2'b01 : 2'b10;
    case (ph)
      0: return first;
      1: return 2'b11;
      2: return balk ? first : ~first;
      default: return 2'b00;
    endcase
  endfunction

  // One clock edge: decide at command level whether it accepts, then advance.
  task automatic tick();
    int   k;
    cmd_t c;
    k = edge_cnt + 1;
    if (!reset && cmd_valid && (k > busy_until)) begin
      c.k    = k;
      c.dir  = cmd_dir;
      c.balk = cmd_balk;
      c.d    = (dwell == 0) ? 1 : int'(dwell);
      exp_q.push_back(c);
      acc_q.push_back(k);
      busy_until = k + 4 * c.d;
      last_k     = k;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      busy_until = 0;
      last_k     = 0;
    end
  endtask

  // Present a command and hold it until the model says it was taken.
  task automatic send(logic dir, logic balk, logic [DW-1:0] dw);
    cmd_dir   = dir;
    cmd_balk  = balk;
    dwell     = dw;
    cmd_valid = 1'b1;
    while (edge_cnt + 1 <= busy_until) tick();
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic idle(int n);
    cmd_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor: compare every cycle against the queue head, pop on completion.
  always @(negedge clk) begin
    int         c;
    logic [1:0] eab;
    logic       edone;
    logic       erdy;
    cmd_t       cur;
    if (mon_en) begin
      c     = edge_cnt + 1;
      eab   = 2'b00;
      edone = 1'b0;
      erdy  = (c > busy_until) || (c <= last_k);
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        if (c > cur.k && c <= cur.k + 4 * cur.d)
          eab = exp_ab(cur.dir, cur.balk, (c - cur.k - 1) / cur.d);
        if (c == cur.k + 4 * cur.d)
          edone = 1'b1;
      end
      chk("ab", int'({a, b}), int'(eab));
      chk("done_tick", int'(done_tick), int'(edone));
      chk("cmd_ready", int'(cmd_ready), int'(erdy));
      chk("busy", int'(busy), int'(!erdy));
      if (edone) void'(exp_q.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Directed sequences
    send(1'b0, 1'b0, 16'd10);
    idle(3);
    send(1'b1, 1'b0, 16'd3);
    idle(2);
    send(1'b0, 1'b1, 16'd5);
    send(1'b1, 1'b1, 16'd2);
    idle(2);

    // dwell = 0, valid held high: enter then exit back to back
    while (edge_cnt + 1 <= busy_until) tick();
    acc_q.delete();
    cmd_dir   = 1'b0;
    cmd_balk  = 1'b0;
    dwell     = '0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() < 2; i++) begin
      tick();
      if (acc_q.size() == 1) cmd_dir = 1'b1;
    end
    cmd_valid = 1'b0;
    chk("accept_count", acc_q.size(), 2);
    if (acc_q.size() == 2) chk("accept_spacing", acc_q[1] - acc_q[0], 5);
    idle(8);

    // Reset during PH2 of an enter with dwell = 8
    send(1'b0, 1'b0, 16'd8);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle(3);

    // Dwell changed during PH1 only affects the next command
    send(1'b0, 1'b0, 16'd4);
    tick();
    dwell = 16'd9;
    tick();
    send(1'b1, 1'b0, 16'd9);
    idle(2);

    // Randomized commands, with random requests and payload while busy
    for (int n = 0; n < 30; n++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 12)));
      for (int j = 0; j < 3; j++) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_balk  = 1'($urandom_range(0, 1));
        dwell     = DW'($urandom_range(0, 12));
        tick();
      end
      idle($urandom_range(0, 2));
    end
    while (edge_cnt + 1 <= busy_until) tick();

    // All-ones dwell: PH1 lasts 65535 cycles, then reset inside PH2
    send(1'b0, 1'b0, 16'hFFFF);
    repeat (65538) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lot_sensor_driver.md
Name: lot_sensor_driver

Overview:
- Transmitter side of the two-sensor parking-lot interface: turns car-movement commands into the a/b photo-sensor waveforms that the occupancy FSM decodes.
- Each command plays a full four-phase sensor sequence with a programmable dwell per phase: enter, exit, or balk (car enters partway then backs out).
- Used as a stimulus and emulation source in front of the occupancy counter, both on the board and in benches.

Parameters:
- DWELL_W, 16, width of the per-phase dwell count in clock cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle and able to accept a command.
- cmd_dir  in  1  0 = enter (a is blocked first), 1 = exit (b is blocked first).
- cmd_balk  in  1  1 = car backs out after both sensors are blocked.
- dwell  in  DWELL_W  cycles per phase, latched on accept; a value of 0 is treated as 1.
- a  out  1  outer sensor (1 = blocked), registered.
- b  out  1  inner sensor (1 = blocked), registered.
- busy  out  1  sequence in progress (equals ~cmd_ready).
- done_tick  out  1  one-cycle pulse in the final cycle of each sequence.

Behaviour:
- Reset: state IDLE; a=0, b=0, done_tick=0, cmd_ready=1, busy=0; the latched command and timer are cleared.
- Accept: a command is accepted on the edge where cmd_valid && cmd_ready. cmd_dir, cmd_balk and D = max(dwell,1) are latched on that edge. Inputs are ignored while busy.
- States: IDLE, PH1, PH2, PH3, GAP. Each non-IDLE state lasts exactly D cycles, timed by a down-counter loaded with D-1 on entry.
- Transitions: IDLE -> PH1 on accept. PH1 -> PH2 -> PH3 -> GAP -> IDLE when the counter reaches 0.
- Output values (a,b) per state:
  - Enter: PH1 (1,0), PH2 (1,1), PH3 (0,1), GAP (0,0).
  - Exit: PH1 (0,1), PH2 (1,1), PH3 (1,0), GAP (0,0).
  - Enter + balk: PH1 (1,0), PH2 (1,1), PH3 (1,0), GAP (0,0).
  - Exit + balk: PH1 (0,1), PH2 (1,1), PH3 (0,1), GAP (0,0).
  - IDLE: (0,0).
- Timing: with accept on edge k, a/b take their PH1 values from cycle k+1 through k+D. PHn covers cycles k+(n-1)D+1 through k+nD. GAP covers k+3D+1 through k+4D.
- done_tick is high only in cycle k+4D. cmd_ready returns high at k+4D+1, so back-to-back commands are spaced 4D+1 cycles apart.
- cmd_ready is decoded from the state register alone, with no combinational path from cmd_valid.
- a and b come straight from flops, glitch-free; exactly one of a/b changes per phase boundary.
- Boundaries:
  - dwell = 0 behaves exactly as dwell = 1.
  - dwell = all-ones gives 2^DWELL_W - 1 cycles per phase with no wrap.
  - Changing the dwell input mid-sequence has no effect.
  - Reset mid-sequence forces a/b to 0 on the next edge, drops the command and emits no done_tick.
  - cmd_valid held high while busy is accepted only once the block is back in IDLE.

Decomposition:
- Shared package lot_sensor_pkg: state encoding (IDLE, PH1, PH2, PH3, GAP), direction constants DIR_ENTER=0 and DIR_EXIT=1, and sensor-pattern constants for the (a,b) pairs.
- One sub-module, phase_timer: load/decrement counter of width DWELL_W with a zero flag, reused by every phase.
- The top level holds the FSM, the command latch and the output registers.

Test Plan:
- Reset, then enter with dwell=10 -> (a,b) = 10/11/01/00 for 10 cycles each; done_tick at cycle k+40; cmd_ready high at k+41.
- Exit with dwell=3 -> (a,b) = 01/11/10/00 for 3 cycles each; done_tick at k+12. Connected occupancy counter reports exactly one exit pulse.
- Enter with balk, dwell=5 -> (a,b) = 10/11/10/00 for 5 cycles each; occupancy counter produces no enter or exit pulse; done_tick at k+20.
- dwell=0 with back-to-back enter then exit and cmd_valid held high -> each phase lasts 1 cycle; second accept exactly 5 cycles after the first.
- Assert reset during PH2 of an enter with dwell=8 -> a=b=0 on the next edge, no done_tick, cmd_ready=1 while reset is held and on release.
- Change dwell from 4 to 9 during PH1 -> all phases keep 4 cycles; the new dwell applies only to the next accepted command.
